// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller and its ALU.
// Holds the FSM state encoding, the opcode and funct values the controller
// recognises, the ALU-op selector used between FSM and ALU decoder, and the
// 3-bit ALU operation codes also consumed by the ALU itself.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPEEX,
        S_RTYPEWB,
        S_BEQEX,
        S_ADDIEX,
        S_ADDIWB,
        S_JEX
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_t;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

endpackage

// File: rtl/mips_aludec.sv
// ALU decoder: maps the FSM's ALU-op selector and the instruction funct field
// to the 3-bit ALU operation code.
// Ports:
//   aluop      - ADD / SUB / FUNCT selector from the controller FSM
//   funct      - instr[5:0]
//   alucontrol - ALU operation code
//   funct_ok   - funct is one of the supported R-type functions
//                (independent of aluop so DECODE can reject bad R-types)
module mips_aludec
    import mips_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alucontrol,
    output logic        funct_ok
);

    logic [2:0] fcode;

    always_comb begin
        funct_ok = 1'b1;
        fcode    = ALU_ADD;
        case (funct)
            FN_ADD:  fcode = ALU_ADD;
            FN_SUB:  fcode = ALU_SUB;
            FN_AND:  fcode = ALU_AND;
            FN_OR:   fcode = ALU_OR;
            FN_SLT:  fcode = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD:   alucontrol = ALU_ADD;
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: alucontrol = fcode;
            default:     alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, ALU decoder for the ALU op input, and a retired-
// instruction counter.
// Ports:
//   clk, reset_n      - clock (rising edge), async active-low reset
//   op, funct         - instruction fields from the instruction register
//   zero              - ALU zero flag, used for beq resolution
//   iord .. pcsrc     - datapath mux selects and write enables
//   pcen              - PC enable = pcwrite | (branch & zero)
//   alucontrol        - ALU operation code
//   illegal           - pulses in DECODE for unsupported opcode/funct
//   instret           - count of completed instructions (wraps)
module mips_mc_controller
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic             pcen,
    output logic [2:0]       alucontrol,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t state, next_state;
    aluop_t aluop;
    logic   pcwrite, branch, funct_ok, retire;

    mips_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol),
        .funct_ok   (funct_ok)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= next_state;
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

    // Every completing state returns to FETCH unconditionally, so being in
    // one of them is the same as retiring on this edge.
    always_comb begin
        retire = 1'b0;
        case (state)
            S_MEMWB, S_MEMWR, S_RTYPEWB, S_ADDIWB, S_BEQEX, S_JEX: retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        illegal    = 1'b0;
        aluop      = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                irwrite    = 1'b1;
                pcwrite    = 1'b1;
                alusrcb    = 2'b01;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_BEQ:       next_state = S_BEQEX;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JEX;
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            next_state = S_RTYPEEX;
                        end else begin
                            illegal    = 1'b1;
                            next_state = S_FETCH;
                        end
                    end
                    default: begin
                        illegal    = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                next_state = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_JEX: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    assign pcen = pcwrite | (branch & zero);

endmodule
